turnstile_gate_scheduler: RTL and testbench

- Shares one pooled credit counter between N_GATES turnstile gates.
- Coins from a common acceptor add credits. Gates raise entry requests; a round-robin arbiter grants one gate at a time. The grant unlocks that gate, waits for the rotation sensor or a timeout, then relocks.
- One credit is consumed per completed passage.
- Sits between the coin acceptor / gate sensors and the gate lock drivers.

---
 rtl/turnstile_gate_scheduler_pkg.sv | 21 ++
 rtl/turnstile_gate_scheduler_rr_arbiter.sv | 35 +++
 rtl/turnstile_gate_scheduler.sv | 141 ++++++++++++++
 tb/tb_turnstile_gate_scheduler.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/turnstile_gate_scheduler_pkg.sv
// Shared types, default parameters and the credit saturation helper for the
// turnstile gate scheduler.
package turnstile_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OPEN  = 2'd1,
        CLOSE = 2'd2
    } state_t;

    localparam int DEF_N_GATES     = 4;
    localparam int DEF_CREDIT_W    = 8;
    localparam int DEF_TIMEOUT_CYC = 16;

    // Callers pass the counter maximum so one helper serves any credit width.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

endpackage

// File: rtl/turnstile_gate_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping around.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx
);

    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    // Scan highest offset first so the closest request to ptr is written last.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        sum       = '0;
        idx       = '0;
        for (int i = N - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + (IW + 1)'(i);
            if (sum >= (IW + 1)'(N)) begin
                sum = sum - (IW + 1)'(N);
            end
            idx = sum[IW-1:0];
            if (req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/turnstile_gate_scheduler.sv
// Pooled-credit turnstile scheduler: round-robin grants, unlock until pass or
// timeout, one relock cycle. Optional alarm via TURNSTILE_TAILGATE_ALARM_EN.
//
// state | meaning
// IDLE  | locked, waiting for credit and a request
// OPEN  | granted gate unlocked, waiting for its pass or the timeout
// CLOSE | forced one-cycle relock before the next grant
module turnstile_gate_scheduler
    import turnstile_pkg::*;
#(
    parameter int N_GATES     = DEF_N_GATES,
    parameter int CREDIT_W    = DEF_CREDIT_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       coin_i,
    input  logic [N_GATES-1:0]         req_i,
    input  logic [N_GATES-1:0]         pass_i,
    output logic [N_GATES-1:0]         unlock_o,
    output logic [$clog2(N_GATES)-1:0] grant_idx_o,
    output logic [CREDIT_W-1:0]        credit_o,
    output logic                       busy_o,
    output logic                       timeout_o
`ifdef TURNSTILE_TAILGATE_ALARM_EN
    ,
    output logic                       tailgate_o,
    output logic [7:0]                 tailgate_cnt_o
`endif
);

    localparam int IW = $clog2(N_GATES);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0]      TIMER_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [IW-1:0]      LAST_GATE  = IW'(N_GATES - 1);
    localparam logic [N_GATES-1:0] ONE_HOT0   = N_GATES'(1);
    localparam logic [31:0]        CREDIT_MAX = 32'((64'd1 << CREDIT_W) - 64'd1);

    state_t               state;
    logic [IW-1:0]        rr_ptr;
    logic [TW-1:0]        timer;
    logic                 gnt_valid;
    logic [IW-1:0]        gnt_idx;
    logic [IW-1:0]        ptr_after;
    logic                 consume;
    logic [CREDIT_W-1:0]  credit_next;

    rr_arbiter #(.N(N_GATES)) u_arb (
        .req       (req_i),
        .ptr       (rr_ptr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign consume   = (state == OPEN) && pass_i[grant_idx_o];
    assign ptr_after = (gnt_idx == LAST_GATE) ? '0 : gnt_idx + IW'(1);

    // A coin and a consumed passage in the same cycle cancel out.
    always_comb begin
        credit_next = credit_o;
        if (coin_i && !consume) begin
            credit_next = CREDIT_W'(sat_inc(32'(credit_o), CREDIT_MAX));
        end else if (consume && !coin_i) begin
            credit_next = credit_o - CREDIT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            credit_o    <= '0;
            rr_ptr      <= '0;
            timer       <= '0;
            unlock_o    <= '0;
            grant_idx_o <= '0;
            busy_o      <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            credit_o  <= credit_next;
            timeout_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (credit_o != '0 && gnt_valid) begin
                        state       <= OPEN;
                        unlock_o    <= ONE_HOT0 << gnt_idx;
                        grant_idx_o <= gnt_idx;
                        timer       <= '0;
                        rr_ptr      <= ptr_after;
                        busy_o      <= 1'b1;
                    end
                end
                OPEN: begin
                    if (consume) begin
                        state    <= CLOSE;
                        unlock_o <= '0;
                    end else if (timer == TIMER_LAST) begin
                        state     <= CLOSE;
                        unlock_o  <= '0;
                        timeout_o <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                CLOSE: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    unlock_o <= '0;
                    busy_o   <= 1'b0;
                end
            endcase
        end
    end

`ifdef TURNSTILE_TAILGATE_ALARM_EN
    logic [N_GATES-1:0] stray;

    // Only the granted gate may rotate, and only while it is unlocked.
    always_comb begin
        stray = pass_i;
        if (state == OPEN) begin
            stray = pass_i & ~(ONE_HOT0 << grant_idx_o);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tailgate_o     <= 1'b0;
            tailgate_cnt_o <= '0;
        end else begin
            tailgate_o <= |stray;
            if (|stray && tailgate_cnt_o != 8'hFF) begin
                tailgate_cnt_o <= tailgate_cnt_o + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_turnstile_gate_scheduler.sv
// Self-checking bench for turnstile_gate_scheduler: directed scenarios plus a
// randomized run against a behavioural model.
module tb_turnstile_gate_scheduler;

    localparam int N  = 4;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coin_i = 1'b0;
    logic [3:0] req_i = '0;
    logic [3:0] pass_i = '0;
    logic [3:0] unlock_o;
    logic [1:0] grant_idx_o;
    logic [7:0] credit_o;
    logic       busy_o;
    logic       timeout_o;
`ifdef TURNSTILE_TAILGATE_ALARM_EN
    logic       tailgate_o;
    logic [7:0] tailgate_cnt_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    turnstile_gate_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .coin_i      (coin_i),
        .req_i       (req_i),
        .pass_i      (pass_i),
        .unlock_o    (unlock_o),
        .grant_idx_o (grant_idx_o),
        .credit_o    (credit_o),
        .busy_o      (busy_o),
        .timeout_o   (timeout_o)
`ifdef TURNSTILE_TAILGATE_ALARM_EN
        ,
        .tailgate_o     (tailgate_o),
        .tailgate_cnt_o (tailgate_cnt_o)
`endif
    );

    // Behavioural model: phase 0 = locked/idle, 1 = gate open, 2 = relock cycle.
    int m_credit, m_ptr, m_phase, m_gate, m_age, m_last;
    bit m_tmo;
    bit m_tg;
    int m_tg_cnt;

    task automatic model_reset();
        m_credit = 0; m_ptr = 0; m_phase = 0; m_gate = 0; m_age = 0;
        m_last = 0; m_tmo = 0; m_tg = 0; m_tg_cnt = 0;
    endtask

    task automatic model_step();
        bit consume;
        int stray;
        consume = (m_phase == 1) && pass_i[m_gate];
        stray = (m_phase == 1) ? int'(pass_i) & ~(1 << m_gate) : int'(pass_i);
        m_tg = (stray != 0);
        if (m_tg && m_tg_cnt < 255) m_tg_cnt++;
        m_tmo = 0;
        if (m_phase == 0) begin
            if (m_credit > 0 && req_i != 0) begin
                for (int i = 0; i < N; i++) begin
                    if (m_phase == 0 && req_i[(m_ptr + i) % N]) begin
                        m_gate = (m_ptr + i) % N;
                        m_phase = 1;
                    end
                end
                m_last = m_gate;
                m_age = 0;
                m_ptr = (m_gate + 1) % N;
            end
        end else if (m_phase == 1) begin
            if (consume) m_phase = 2;
            else if (m_age == TO - 1) begin m_tmo = 1; m_phase = 2; end
            else m_age++;
        end else begin
            m_phase = 0;
        end
        if (coin_i && !consume) m_credit = (m_credit >= 255) ? 255 : m_credit + 1;
        else if (consume && !coin_i) m_credit = m_credit - 1;
    endtask

    function automatic logic [15:0] model_vec();
        logic [3:0] u;
        u = (m_phase == 1) ? 4'(1 << m_gate) : 4'd0;
        return {u, 2'(m_last), 8'(m_credit), (m_phase != 0), m_tmo};
    endfunction

    task automatic tick(input bit c, input logic [3:0] r, input logic [3:0] p);
        @(negedge clk);
        coin_i = c; req_i = r; pass_i = p;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; coin_i = 0; req_i = '0; pass_i = '0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (unlock_o !== 4'b0) begin n_errors++; $display("FAIL reset_unlock got %b exp 0000", unlock_o); end
        n_checks++;
        if (credit_o !== 8'd0) begin n_errors++; $display("FAIL reset_credit got %0d exp 0", credit_o); end
        n_checks++;
        if ({grant_idx_o, busy_o, timeout_o} !== 4'b0) begin
            n_errors++; $display("FAIL reset_misc got idx=%0d busy=%b tmo=%b exp 0", grant_idx_o, busy_o, timeout_o);
        end
    endtask

    task automatic test_single_pass();
        repeat (3) tick(1, 4'b0000, 4'b0000);
        n_checks++;
        if (credit_o !== 8'd3) begin n_errors++; $display("FAIL coin_credit got %0d exp 3", credit_o); end
        tick(0, 4'b0001, 4'b0000);
        n_checks++;
        if ({unlock_o, grant_idx_o, busy_o} !== {4'b0001, 2'd0, 1'b1}) begin
            n_errors++; $display("FAIL grant_latency got %b/%0d/%b exp 0001/0/1", unlock_o, grant_idx_o, busy_o);
        end
        tick(0, 4'b0001, 4'b0000);
        tick(0, 4'b0001, 4'b0001);
        n_checks++;
        if ({unlock_o, credit_o, busy_o} !== {4'b0000, 8'd2, 1'b1}) begin
            n_errors++; $display("FAIL pass_consume got %b/%0d/%b exp 0000/2/1", unlock_o, credit_o, busy_o);
        end
        tick(0, 4'b0001, 4'b0000);
        n_checks++;
        if ({unlock_o, busy_o} !== 5'b0) begin n_errors++; $display("FAIL close_one_cycle got %b/%b exp 0000/0", unlock_o, busy_o); end
        tick(0, 4'b0001, 4'b0000);
        n_checks++;
        if (unlock_o !== 4'b0001) begin n_errors++; $display("FAIL regrant got %b exp 0001", unlock_o); end
        tick(0, 4'b0001, 4'b0001);
        tick(0, 4'b0000, 4'b0000);
    endtask

    task automatic test_round_robin();
        tick(1, 4'b0000, 4'b0000);
        n_checks++;
        if (credit_o !== 8'd2) begin n_errors++; $display("FAIL rr_credit_start got %0d exp 2", credit_o); end
        tick(0, 4'b1010, 4'b0000);
        n_checks++;
        if ({unlock_o, grant_idx_o} !== {4'b0010, 2'd1}) begin n_errors++; $display("FAIL rr_first got %b/%0d exp 0010/1", unlock_o, grant_idx_o); end
        tick(0, 4'b1010, 4'b0010);
        n_checks++;
        if (credit_o !== 8'd1) begin n_errors++; $display("FAIL rr_credit1 got %0d exp 1", credit_o); end
        tick(0, 4'b1010, 4'b0000);
        tick(0, 4'b1010, 4'b0000);
        n_checks++;
        if ({unlock_o, grant_idx_o} !== {4'b1000, 2'd3}) begin n_errors++; $display("FAIL rr_second got %b/%0d exp 1000/3", unlock_o, grant_idx_o); end
        tick(0, 4'b1010, 4'b1000);
        n_checks++;
        if (credit_o !== 8'd0) begin n_errors++; $display("FAIL rr_credit0 got %0d exp 0", credit_o); end
        for (int i = 0; i < 4; i++) begin
            tick(0, 4'b1010, 4'b0000);
            n_checks++;
            if (unlock_o !== 4'b0000) begin n_errors++; $display("FAIL no_credit_grant cyc %0d got %b exp 0000", i, unlock_o); end
        end
    endtask

    task automatic test_timeout();
        tick(1, 4'b0000, 4'b0000);
        tick(0, 4'b0100, 4'b0000);
        n_checks++;
        if ({unlock_o, grant_idx_o} !== {4'b0100, 2'd2}) begin n_errors++; $display("FAIL to_grant got %b/%0d exp 0100/2", unlock_o, grant_idx_o); end
        for (int i = 1; i < TO; i++) begin
            tick(0, 4'b0100, 4'b0000);
            n_checks++;
            if ({unlock_o, timeout_o} !== {4'b0100, 1'b0}) begin
                n_errors++; $display("FAIL to_hold cyc %0d got %b/%b exp 0100/0", i, unlock_o, timeout_o);
            end
        end
        tick(0, 4'b0100, 4'b0000);
        n_checks++;
        if ({unlock_o, timeout_o, credit_o} !== {4'b0000, 1'b1, 8'd1}) begin
            n_errors++; $display("FAIL to_expire got %b/%b/%0d exp 0000/1/1", unlock_o, timeout_o, credit_o);
        end
        tick(0, 4'b0101, 4'b0000);
        n_checks++;
        if (timeout_o !== 1'b0) begin n_errors++; $display("FAIL to_pulse_width got %b exp 0", timeout_o); end
        tick(0, 4'b0101, 4'b0000);
        n_checks++;
        if ({unlock_o, grant_idx_o} !== {4'b0001, 2'd0}) begin n_errors++; $display("FAIL to_fairness got %b/%0d exp 0001/0", unlock_o, grant_idx_o); end
        tick(0, 4'b0101, 4'b0001);
        tick(0, 4'b0000, 4'b0000);
    endtask

    task automatic test_coin_and_pass();
        repeat (5) tick(1, 4'b0000, 4'b0000);
        tick(0, 4'b0001, 4'b0000);
        n_checks++;
        if ({unlock_o, credit_o} !== {4'b0001, 8'd5}) begin n_errors++; $display("FAIL cp_grant got %b/%0d exp 0001/5", unlock_o, credit_o); end
        tick(1, 4'b0001, 4'b0001);
        n_checks++;
        if ({unlock_o, credit_o} !== {4'b0000, 8'd5}) begin n_errors++; $display("FAIL cp_net got %b/%0d exp 0000/5", unlock_o, credit_o); end
        tick(0, 4'b0000, 4'b0000);
    endtask

    task automatic test_saturation_async_reset();
        do_reset();
        repeat (255) tick(1, 4'b0000, 4'b0000);
        n_checks++;
        if (credit_o !== 8'd255) begin n_errors++; $display("FAIL sat_fill got %0d exp 255", credit_o); end
        tick(1, 4'b0000, 4'b0000);
        n_checks++;
        if (credit_o !== 8'd255) begin n_errors++; $display("FAIL sat_hold got %0d exp 255", credit_o); end
        tick(0, 4'b0010, 4'b0000);
        n_checks++;
        if (unlock_o !== 4'b0010) begin n_errors++; $display("FAIL sat_grant got %b exp 0010", unlock_o); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({unlock_o, credit_o, busy_o} !== 13'b0) begin
            n_errors++; $display("FAIL async_reset got %b/%0d/%b exp 0000/0/0", unlock_o, credit_o, busy_o);
        end
        @(negedge clk);
        req_i = '0;
        rst_n = 1'b1;
        model_reset();
    endtask

`ifdef TURNSTILE_TAILGATE_ALARM_EN
    task automatic test_tailgate();
        do_reset();
        tick(1, 4'b0000, 4'b0000);
        tick(0, 4'b0001, 4'b0000);
        tick(0, 4'b0001, 4'b0100);
        n_checks++;
        if ({tailgate_o, tailgate_cnt_o, unlock_o, credit_o} !== {1'b1, 8'd1, 4'b0001, 8'd1}) begin
            n_errors++; $display("FAIL tailgate got %b/%0d/%b/%0d exp 1/1/0001/1", tailgate_o, tailgate_cnt_o, unlock_o, credit_o);
        end
        tick(0, 4'b0001, 4'b0000);
        n_checks++;
        if ({tailgate_o, unlock_o} !== {1'b0, 4'b0001}) begin
            n_errors++; $display("FAIL tailgate_pulse got %b/%b exp 0/0001", tailgate_o, unlock_o);
        end
    endtask
`endif

    task automatic test_random();
        logic [3:0] r, p;
        bit c;
        do_reset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            c = ($urandom_range(0, 2) == 0);
            r = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            p = '0;
            if (m_phase == 1 && $urandom_range(0, 5) == 0) p = 4'(1 << m_gate);
            if ($urandom_range(0, 15) == 0) p = p | 4'($urandom_range(0, 15));
            tick(c, r, p);
            n_checks++;
            if ({unlock_o, grant_idx_o, credit_o, busy_o, timeout_o} !== model_vec()) begin
                n_errors++;
                $display("FAIL random cyc %0d outputs got %h exp %h", cyc,
                         {unlock_o, grant_idx_o, credit_o, busy_o, timeout_o}, model_vec());
            end
`ifdef TURNSTILE_TAILGATE_ALARM_EN
            n_checks++;
            if ({tailgate_o, tailgate_cnt_o} !== {m_tg, 8'(m_tg_cnt)}) begin
                n_errors++;
                $display("FAIL random_tailgate cyc %0d got %b/%0d exp %b/%0d", cyc, tailgate_o, tailgate_cnt_o, m_tg, m_tg_cnt);
            end
`endif
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_pass();
        test_round_robin();
        test_timeout();
        test_coin_and_pass();
        test_saturation_async_reset();
`ifdef TURNSTILE_TAILGATE_ALARM_EN
        test_tailgate();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
